// File: rtl/matmul_sched_pkg.sv
// Shared types for the matmul job scheduler: command record, FSM states and
// completion status codes.
package matmul_sched_pkg;

   localparam int CMD_TAG_W = 4;

   typedef struct packed {
      logic [15:0]          m;
      logic [15:0]          n;
      logic [15:0]          p;
      logic [15:0]          base_a;
      logic [15:0]          base_b;
      logic [15:0]          base_c;
      logic [CMD_TAG_W-1:0] tag;
   } matmul_cmd_t;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_CPL, S_HALTED
   } sched_state_e;

   typedef enum logic [1:0] {
      CPL_OK       = 2'd0,
      CPL_REJECTED = 2'd1,
      CPL_TIMEOUT  = 2'd2
   } cpl_status_e;

   function automatic logic dim_bad(input logic [15:0] d, input logic [15:0] max_d);
      return (d == 16'd0) || (d > max_d);
   endfunction

endpackage

// File: rtl/matmul_cmd_fifo.sv
// Command queue for the scheduler; occupancy is a registered count so
// full/empty never depend on same-cycle push/pop.
module matmul_cmd_fifo
   import matmul_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        push_i,
   input  matmul_cmd_t data_i,
   input  logic        pop_i,
   output matmul_cmd_t data_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = $clog2(DEPTH);

   matmul_cmd_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/matmul_job_scheduler.sv
// Issues queued matmul jobs to the systolic array one at a time and returns a
// tagged completion (ok / rejected / timeout) per job.
module matmul_job_scheduler
   import matmul_sched_pkg::*;
#(
   parameter int CMD_DEPTH      = 4,
   parameter int TAG_WIDTH      = CMD_TAG_W,
   parameter int MAX_DIM        = 1024,
   parameter int TIMEOUT_CYCLES = 1 << 20
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [15:0]          cmd_m_i,
   input  logic [15:0]          cmd_n_i,
   input  logic [15:0]          cmd_p_i,
   input  logic [15:0]          cmd_base_a_i,
   input  logic [15:0]          cmd_base_b_i,
   input  logic [15:0]          cmd_base_c_i,
   input  logic [TAG_WIDTH-1:0] cmd_tag_i,
   output logic                 array_start_o,
   output logic [15:0]          m_o,
   output logic [15:0]          n_o,
   output logic [15:0]          p_o,
   output logic [15:0]          base_addr_a_o,
   output logic [15:0]          base_addr_b_o,
   output logic [15:0]          base_addr_c_o,
   input  logic                 array_done_i,
   output logic                 cpl_valid_o,
   input  logic                 cpl_ready_i,
   output logic [TAG_WIDTH-1:0] cpl_tag_o,
   output logic [1:0]           cpl_status_o,
   output logic                 busy_o,
   input  logic                 clear_i
);

   localparam logic [15:0] MAX_DIM_W = MAX_DIM[15:0];
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

   sched_state_e state_q;
   matmul_cmd_t  job_q, cmd_in, fifo_head;
   cpl_status_e  status_q;
   logic         start_q, cpl_valid_q, halt_q, done_q;
   logic [31:0]  cnt_q, cnt_inc;
   logic         fifo_full, fifo_empty, push, pop;

   assign cmd_in = '{m: cmd_m_i, n: cmd_n_i, p: cmd_p_i,
                     base_a: cmd_base_a_i, base_b: cmd_base_b_i, base_c: cmd_base_c_i,
                     tag: CMD_TAG_W'(cmd_tag_i)};
   assign push = cmd_valid_i && !fifo_full;
   assign pop  = (state_q == S_IDLE) && !fifo_empty;

   matmul_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .data_i  (cmd_in),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Counter value after this WAIT cycle; timeout fires the cycle it reaches the limit.
   assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         job_q       <= '0;
         status_q    <= CPL_OK;
         start_q     <= 1'b0;
         cpl_valid_q <= 1'b0;
         halt_q      <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         done_q  <= array_done_i;
         start_q <= 1'b0;
         case (state_q)
            S_IDLE: if (pop) begin
               job_q   <= fifo_head;
               state_q <= S_CHECK;
            end
            S_CHECK: if (dim_bad(job_q.m, MAX_DIM_W) || dim_bad(job_q.n, MAX_DIM_W) ||
                         dim_bad(job_q.p, MAX_DIM_W)) begin
               status_q    <= CPL_REJECTED;
               cpl_valid_q <= 1'b1;
               state_q     <= S_CPL;
            end else begin
               start_q <= 1'b1;
               state_q <= S_ISSUE;
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            // done_q already holds the level seen during ISSUE, so a stale high never counts.
            S_WAIT: if (array_done_i && !done_q) begin
               status_q    <= CPL_OK;
               cpl_valid_q <= 1'b1;
               state_q     <= S_CPL;
            end else if (cnt_inc >= TO_LAST) begin
               status_q    <= CPL_TIMEOUT;
               cpl_valid_q <= 1'b1;
               halt_q      <= 1'b1;
               state_q     <= S_CPL;
            end else begin
               cnt_q <= cnt_inc;
            end
            S_CPL: if (cpl_ready_i) begin
               cpl_valid_q <= 1'b0;
               state_q     <= halt_q ? S_HALTED : S_IDLE;
            end
            S_HALTED: if (clear_i) begin
               halt_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready_o   = !fifo_full;
   assign array_start_o = start_q;
   assign m_o           = job_q.m;
   assign n_o           = job_q.n;
   assign p_o           = job_q.p;
   assign base_addr_a_o = job_q.base_a;
   assign base_addr_b_o = job_q.base_b;
   assign base_addr_c_o = job_q.base_c;
   assign cpl_valid_o   = cpl_valid_q;
   assign cpl_tag_o     = TAG_WIDTH'(job_q.tag);
   assign cpl_status_o  = status_q;
   assign busy_o        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed scenario bench for matmul_job_scheduler (TIMEOUT_CYCLES=100, MAX_DIM=1024).
module tb_matmul_job_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [15:0] cmd_m_i = '0, cmd_n_i = '0, cmd_p_i = '0;
   logic [15:0] cmd_base_a_i = '0, cmd_base_b_i = '0, cmd_base_c_i = '0;
   logic [3:0]  cmd_tag_i = '0;
   logic        array_start_o;
   logic [15:0] m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o;
   logic        array_done_i = 1'b0;
   logic        cpl_valid_o;
   logic        cpl_ready_i = 1'b0;
   logic [3:0]  cpl_tag_o;
   logic [1:0]  cpl_status_o;
   logic        busy_o;
   logic        clear_i = 1'b0;

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;

   matmul_job_scheduler #(
      .CMD_DEPTH(4), .TAG_WIDTH(4), .MAX_DIM(1024), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_m_i(cmd_m_i), .cmd_n_i(cmd_n_i), .cmd_p_i(cmd_p_i),
      .cmd_base_a_i(cmd_base_a_i), .cmd_base_b_i(cmd_base_b_i), .cmd_base_c_i(cmd_base_c_i),
      .cmd_tag_i(cmd_tag_i),
      .array_start_o(array_start_o),
      .m_o(m_o), .n_o(n_o), .p_o(p_o),
      .base_addr_a_o(base_addr_a_o), .base_addr_b_o(base_addr_b_o), .base_addr_c_o(base_addr_c_o),
      .array_done_i(array_done_i),
      .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i),
      .cpl_tag_o(cpl_tag_o), .cpl_status_o(cpl_status_o),
      .busy_o(busy_o), .clear_i(clear_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (array_start_o) start_cnt <= start_cnt + 1;

   // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] m, input logic [15:0] n, input logic [15:0] p,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [3:0] tag);
      cmd_valid_i = 1'b1;
      cmd_m_i = m; cmd_n_i = n; cmd_p_i = p;
      cmd_base_a_i = a; cmd_base_b_i = b; cmd_base_c_i = c;
      cmd_tag_i = tag;
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_start(output int edges);
      edges = 0;
      while (array_start_o !== 1'b1 && edges < 200) begin tick(); edges++; end
   endtask

   task automatic wait_cpl(output int edges);
      edges = 0;
      while (cpl_valid_o !== 1'b1 && edges < 200) begin tick(); edges++; end
   endtask

   task automatic handshake();
      cpl_ready_i = 1'b1;
      tick();
      cpl_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      checks++;
      if ({cmd_ready_o, array_start_o, cpl_valid_o, busy_o} !== 4'b1000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 1000", {cmd_ready_o, array_start_o, cpl_valid_o, busy_o});
      end
      checks++;
      if ({m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o, cpl_tag_o, cpl_status_o} !== '0) begin
         errors++; $display("FAIL reset_data: m=%0d n=%0d p=%0d tag=%0d st=%0d want all 0", m_o, n_o, p_o, cpl_tag_o, cpl_status_o);
      end
   endtask

   task automatic test_single();
      int e;
      push(16'd4, 16'd8, 16'd32, 16'h0100, 16'h0200, 16'h0300, 4'd3);
      // Start appears in the cycle closing at edge T+3, i.e. seen 2 edges after the push edge.
      wait_start(e);
      checks++;
      if (e != 2) begin errors++; $display("FAIL single_start_lat: got %0d edges want 2", e); end
      checks++;
      if ({m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o} !==
          {16'd4, 16'd8, 16'd32, 16'h0100, 16'h0200, 16'h0300}) begin
         errors++; $display("FAIL single_params: got m=%0d n=%0d p=%0d a=%h b=%h c=%h", m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o);
      end
      tick();
      checks++;
      if (array_start_o !== 1'b0) begin errors++; $display("FAIL single_pulse_width: start=%b want 0", array_start_o); end
      repeat (49) tick();
      checks++;
      if (cpl_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++; $display("FAIL single_wait: cpl_valid=%b busy=%b want 0 1", cpl_valid_o, busy_o);
      end
      array_done_i = 1'b1;
      tick();
      array_done_i = 1'b0;
      checks++;
      if ({cpl_valid_o, cpl_tag_o, cpl_status_o} !== {1'b1, 4'd3, 2'd0}) begin
         errors++; $display("FAIL single_cpl: valid=%b tag=%0d st=%0d want 1 3 0", cpl_valid_o, cpl_tag_o, cpl_status_o);
      end
      checks++;
      if (m_o !== 16'd4 || p_o !== 16'd32) begin errors++; $display("FAIL single_hold: m=%0d p=%0d want 4 32", m_o, p_o); end
      handshake();
      checks++;
      if (cpl_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL single_idle: cpl_valid=%b busy=%b want 0 0", cpl_valid_o, busy_o);
      end
   endtask

   task automatic test_back_to_back();
      int e, s0;
      s0 = start_cnt;
      push(16'd2, 16'd2, 16'd2, 16'h0010, 16'h0020, 16'h0030, 4'd10);
      wait_start(e);
      for (int t = 0; t < 4; t++) push(16'd1 + 16'(t), 16'd3, 16'd5, 16'(t), 16'h0, 16'h0, 4'(t));
      checks++;
      if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL queue_full_ready: got %b want 0", cmd_ready_o); end
      push(16'd9, 16'd9, 16'd9, 16'h0, 16'h0, 16'h0, 4'd7);
      array_done_i = 1'b1;
      tick();
      array_done_i = 1'b0;
      checks++;
      if ({cpl_valid_o, cpl_tag_o, cpl_status_o} !== {1'b1, 4'd10, 2'd0}) begin
         errors++; $display("FAIL queue_cpl_first: valid=%b tag=%0d st=%0d want 1 10 0", cpl_valid_o, cpl_tag_o, cpl_status_o);
      end
      for (int t = 0; t < 4; t++) begin
         handshake();
         wait_start(e);
         checks++;
         if (e != 2 || m_o !== 16'd1 + 16'(t)) begin
            errors++; $display("FAIL b2b_start_%0d: edges=%0d m=%0d want 2 %0d", t, e, m_o, t + 1);
         end
         tick(); tick();
         array_done_i = 1'b1;
         tick();
         array_done_i = 1'b0;
         checks++;
         if ({cpl_valid_o, cpl_tag_o, cpl_status_o} !== {1'b1, 4'(t), 2'd0}) begin
            errors++; $display("FAIL queue_order_%0d: valid=%b tag=%0d st=%0d want 1 %0d 0", t, cpl_valid_o, cpl_tag_o, cpl_status_o, t);
         end
      end
      handshake();
      repeat (5) tick();
      checks++;
      if (start_cnt - s0 != 5 || busy_o !== 1'b0) begin
         errors++; $display("FAIL queue_starts: starts=%0d busy=%b want 5 0", start_cnt - s0, busy_o);
      end
   endtask

   task automatic test_reject();
      int e, s0;
      s0 = start_cnt;
      push(16'd4, 16'd0, 16'd4, 16'h0, 16'h0, 16'h0, 4'd1);
      push(16'd4, 16'd4, 16'd2000, 16'h0, 16'h0, 16'h0, 4'd2);
      wait_cpl(e);
      checks++;
      if (e != 1 || cpl_tag_o !== 4'd1 || cpl_status_o !== 2'd1) begin
         errors++; $display("FAIL reject_n0: edges=%0d tag=%0d st=%0d want 1 1 1", e, cpl_tag_o, cpl_status_o);
      end
      handshake();
      wait_cpl(e);
      checks++;
      if (e != 2 || cpl_tag_o !== 4'd2 || cpl_status_o !== 2'd1) begin
         errors++; $display("FAIL reject_p2000: edges=%0d tag=%0d st=%0d want 2 2 1", e, cpl_tag_o, cpl_status_o);
      end
      handshake();
      tick();
      checks++;
      if (start_cnt != s0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL reject_no_start: starts=%0d busy=%b want 0 0", start_cnt - s0, busy_o);
      end
   endtask

   task automatic test_timeout();
      int e, s0;
      push(16'd8, 16'd8, 16'd8, 16'h0, 16'h0, 16'h0, 4'd4);
      push(16'd7, 16'd6, 16'd5, 16'h0, 16'h0, 16'h0, 4'd5);
      wait_start(e);
      wait_cpl(e);
      checks++;
      if (e != 100 || cpl_tag_o !== 4'd4 || cpl_status_o !== 2'd2) begin
         errors++; $display("FAIL timeout_cpl: edges=%0d tag=%0d st=%0d want 100 4 2", e, cpl_tag_o, cpl_status_o);
      end
      handshake();
      s0 = start_cnt;
      repeat (10) tick();
      checks++;
      if (start_cnt != s0 || busy_o !== 1'b1 || cmd_ready_o !== 1'b1 || m_o !== 16'd8) begin
         errors++; $display("FAIL halted_hold: starts=%0d busy=%b ready=%b m=%0d want 0 1 1 8", start_cnt - s0, busy_o, cmd_ready_o, m_o);
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      wait_start(e);
      checks++;
      if (e != 2 || m_o !== 16'd7 || n_o !== 16'd6 || p_o !== 16'd5) begin
         errors++; $display("FAIL clear_issue: edges=%0d m=%0d n=%0d p=%0d want 2 7 6 5", e, m_o, n_o, p_o);
      end
      tick(); tick();
      clear_i = 1'b1;   // outside HALTED this must be ignored
      tick();
      clear_i = 1'b0;
      array_done_i = 1'b1;
      tick();
      array_done_i = 1'b0;
      checks++;
      if ({cpl_valid_o, cpl_tag_o, cpl_status_o} !== {1'b1, 4'd5, 2'd0}) begin
         errors++; $display("FAIL clear_cpl: valid=%b tag=%0d st=%0d want 1 5 0", cpl_valid_o, cpl_tag_o, cpl_status_o);
      end
      handshake();
      tick();
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL clear_idle: busy=%b want 0", busy_o); end
   endtask

   task automatic test_stale_done();
      int e, bad;
      push(16'd3, 16'd3, 16'd3, 16'h0, 16'h0, 16'h0, 4'd6);
      wait_start(e);
      tick(); tick();
      array_done_i = 1'b1;
      tick();
      push(16'd5, 16'd5, 16'd5, 16'h0, 16'h0, 16'h0, 4'd7);
      checks++;
      if (cpl_tag_o !== 4'd6 || cpl_valid_o !== 1'b1) begin
         errors++; $display("FAIL stale_first: valid=%b tag=%0d want 1 6", cpl_valid_o, cpl_tag_o);
      end
      handshake();
      wait_start(e);
      repeat (10) tick();
      checks++;
      if (cpl_valid_o !== 1'b0) begin errors++; $display("FAIL stale_level: cpl_valid=%b want 0", cpl_valid_o); end
      array_done_i = 1'b0;
      repeat (3) tick();
      array_done_i = 1'b1;
      tick();
      checks++;
      if ({cpl_valid_o, cpl_tag_o, cpl_status_o} !== {1'b1, 4'd7, 2'd0}) begin
         errors++; $display("FAIL stale_rise: valid=%b tag=%0d st=%0d want 1 7 0", cpl_valid_o, cpl_tag_o, cpl_status_o);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if ({cpl_valid_o, cpl_tag_o, cpl_status_o} !== {1'b1, 4'd7, 2'd0}) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL cpl_hold: unstable cycles=%0d want 0", bad); end
      handshake();
      array_done_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int e, s0;
      push(16'd6, 16'd6, 16'd6, 16'h0, 16'h0, 16'h0, 4'd8);
      push(16'd6, 16'd6, 16'd6, 16'h0, 16'h0, 16'h0, 4'd9);
      wait_start(e);
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++;
      if ({cmd_ready_o, array_start_o, cpl_valid_o, busy_o, m_o, cpl_tag_o, cpl_status_o} !== {4'b1000, 16'd0, 4'd0, 2'd0}) begin
         errors++; $display("FAIL reset_mid: ready=%b start=%b cpl=%b busy=%b m=%0d want 1 0 0 0 0", cmd_ready_o, array_start_o, cpl_valid_o, busy_o, m_o);
      end
      s0 = start_cnt;
      array_done_i = 1'b1;
      repeat (20) tick();
      array_done_i = 1'b0;
      checks++;
      if (cpl_valid_o !== 1'b0 || start_cnt != s0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL reset_mid_quiet: cpl=%b starts=%0d busy=%b want 0 0 0", cpl_valid_o, start_cnt - s0, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reject();
      test_timeout();
      test_stale_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matmul_job_scheduler.md
Name: matmul_job_scheduler

Overview:
- Queues matrix-multiply jobs from the config side and issues them one at a time to systolic_array_top.
- Drives start_i, holds m/n/p and base_addr_a/b/c stable for the whole job, and detects completion from operation_done.
- Returns a tagged completion record per job, with status ok, rejected or timeout.
- Sits between the config/register block and systolic_array_top, in the core clk domain.

Parameters:
- CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
- TAG_WIDTH, 4, width of the job tag.
- MAX_DIM, 1024, largest legal value of m, n and p.
- TIMEOUT_CYCLES, 1<<20, cycles allowed from start pulse to done rise.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset; synchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  FIFO not full.
- cmd_m_i / cmd_n_i / cmd_p_i  in  16 each  job dimensions.
- cmd_base_a_i / cmd_base_b_i / cmd_base_c_i  in  16 each  job base addresses.
- cmd_tag_i  in  TAG_WIDTH  job tag.
- array_start_o  out  1  one-cycle start pulse to the array.
- m_o / n_o / p_o / base_addr_a_o / base_addr_b_o / base_addr_c_o  out  16 each  job parameters to the array.
- array_done_i  in  1  operation_done, level, already synchronised to clk.
- cpl_valid_o  out  1  completion record valid.
- cpl_ready_i  in  1  completion record consumed.
- cpl_tag_o  out  TAG_WIDTH  tag of the completed job.
- cpl_status_o  out  2  0=OK, 1=REJECTED, 2=TIMEOUT.
- busy_o  out  1  FSM not IDLE, or FIFO not empty.
- clear_i  in  1  leaves the HALTED state.

Behaviour:
- Reset (reset_n low at a clk edge):
  - FIFO is emptied, FSM goes to IDLE.
  - All outputs are 0, except cmd_ready_o=1.
- Command push: push when cmd_valid_i && cmd_ready_o. cmd_ready_o = !full, registered count based.
- FSM states:
  - IDLE: if FIFO not empty, pop the head into the job registers and go to CHECK.
  - CHECK (1 cycle): if any of m/n/p is 0 or greater than MAX_DIM, set status=REJECTED and go to CPL; otherwise go to ISSUE.
  - ISSUE (1 cycle): array_start_o=1; clear the timeout counter; capture done_d=array_done_i; go to WAIT.
  - WAIT: done_rise = array_done_i && !done_d, with done_d registered every cycle.
    - On done_rise: status=OK, go to CPL.
    - When the counter reaches TIMEOUT_CYCLES-1 without a rise: status=TIMEOUT, go to CPL, set halt_pending.
  - CPL: cpl_valid_o=1 with tag/status stable until cpl_ready_i. On the handshake go to HALTED if halt_pending, else IDLE.
  - HALTED: no issue. Queued commands are retained and pushes are still accepted. clear_i clears halt_pending and goes to IDLE.
- Latency:
  - A push at edge T into an empty FIFO with the FSM in IDLE gives the pop at T+1 and array_start_o high in cycle T+3.
  - A rejected job gives cpl_valid_o high in cycle T+3.
  - Back-to-back: the next job's start follows the cpl handshake by 3 cycles.
- m_o..base_addr_c_o change only on a pop; they are held through WAIT and CPL.
- Push and pop in the same cycle when full is not allowed, because ready=0. Push and pop when empty is impossible, because the pop sees the registered count.
- Done level high before ISSUE does not complete the job; only a 0->1 transition after the start pulse counts.
- clear_i in any state other than HALTED is ignored.
- The timeout counter is 32 bits wide and saturates; it is not wrap-sensitive.

Decomposition:
- Package matmul_sched_pkg:
  - typedef matmul_cmd_t (m, n, p, base_a, base_b, base_c, tag).
  - enum sched_state_e.
  - enum cpl_status_e with values OK, REJECTED, TIMEOUT.
- Sub-module matmul_cmd_fifo: synchronous FIFO of matmul_cmd_t, parameterised by CMD_DEPTH; push/pop/full/empty, synchronous active-low reset.

Test Plan:
- Single job: push m=4, n=8, p=32, tag=3.
  - Expect start pulse in cycle T+3 and outputs equal to the command.
  - Raise done 50 cycles later: expect cpl_valid with tag=3, status=0; busy_o drops after the handshake.
- Queue four jobs with tags 0..3 while the array is busy.
  - The 5th push sees cmd_ready_o=0.
  - Completions arrive in tag order 0,1,2,3, exactly one start pulse per job.
- Invalid dimensions: push n=0, then p=2000 (MAX_DIM=1024).
  - Expect two REJECTED completions and no array_start_o pulse.
- Timeout: TIMEOUT_CYCLES=100, done never rises.
  - TIMEOUT is reported at start+100, then the FSM is HALTED with a queued job unissued.
  - clear_i issues the queued job.
- Stale done: array_done_i held high from the previous job across ISSUE.
  - No completion until done drops and rises again.
  - cpl_ready_i held low 20 cycles keeps tag/status stable.
- Reset mid-WAIT: reset_n low 1 cycle.
  - All outputs go to 0, cmd_ready_o=1, FIFO empty, no completion emitted.
